if_fetch_unit: RTL

- Instruction-fetch stage that sits directly upstream of the control decoder in the RV32I core.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Presents the fetched word, and its Op/Funct3/Funct7 fields, to the decoder.
- Computes the next PC from the decoder's NPCOp, the immediate, and the ALU result when the core retires the current instruction.

---
 rtl/if_fetch_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// presents the held instruction and its decode fields to the control decoder.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        retire,
  input  logic [2:0]  NPCOp,
  input  logic [31:0] immout,
  input  logic [31:0] aluout,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [6:0]  Op,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  output logic        bus_err,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic        TIMEOUT_EN   = (ACK_TIMEOUT != 0);
  localparam logic [31:0] TIMEOUT_LAST = 32'(ACK_TIMEOUT) - 32'd1;

  state_t      state;
  logic [31:0] ack_cnt;
  logic [31:0] npc;
  logic        npc_misaligned;

  // Unknown NPCOp encodings fall back to sequential flow; jalr clears bit 0.
  function automatic logic [31:0] calc_npc(input logic [2:0]  op,
                                           input logic [31:0] pc,
                                           input logic [31:0] imm,
                                           input logic [31:0] alu);
    logic [31:0] res;
    case (op)
      3'b000:  res = pc + 32'd4;
      3'b001:  res = pc + imm;
      3'b010:  res = pc + imm;
      3'b100:  res = alu & 32'hFFFF_FFFE;
      default: res = pc + 32'd4;
    endcase
    return res;
  endfunction

  // Next-PC candidate and its alignment check for the retiring instruction.
  always_comb begin
    npc            = calc_npc(NPCOp, pc_out, immout, aluout);
    npc_misaligned = (npc[1:0] != 2'b00);
  end

  assign imem_addr = pc_out;
  assign Op        = inst_valid ? inst_out[6:0]   : 7'd0;
  assign Funct3    = inst_valid ? inst_out[14:12] : 3'd0;
  assign Funct7    = inst_valid ? inst_out[31:25] : 7'd0;

  // Fetch FSM with all handshake, PC and flag outputs registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      pc_out     <= RESET_PC;
      inst_out   <= 32'd0;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
      bus_err    <= 1'b0;
      misalign   <= 1'b0;
      ack_cnt    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          ack_cnt  <= 32'd0;
        end
        FETCH: begin
          // An ack arriving on the final allowed cycle still counts.
          if (imem_ack) begin
            inst_out   <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            ack_cnt    <= 32'd0;
            state      <= HOLD;
          end else if (TIMEOUT_EN && (ack_cnt == TIMEOUT_LAST)) begin
            bus_err  <= 1'b1;
            imem_req <= 1'b0;
            state    <= ERR;
          end else begin
            ack_cnt <= ack_cnt + 32'd1;
          end
        end
        HOLD: begin
          if (retire) begin
            if (npc_misaligned) begin
              misalign   <= 1'b1;
              inst_valid <= 1'b0;
              state      <= ERR;
            end else begin
              pc_out     <= npc;
              inst_valid <= 1'b0;
              imem_req   <= 1'b1;
              state      <= FETCH;
            end
          end else begin
            inst_valid <= 1'b1;
          end
        end
        ERR: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
